// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue unit: FSM encoding, default widths and the queue entry.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_DATA_W  = 32;
  localparam int FETCH_PC_STEP = 4;

  typedef enum logic [1:0] {
    S_BOOT     = 2'd0,
    S_RUN      = 2'd1,
    S_REDIRECT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_unit_if.sv
// Instruction-memory request/response channel and the ID-facing valid/ready channel.
interface fetch_queue_unit_if import fetch_pkg::*; #(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_gnt, imem_rvalid, imem_rdata, out_ready
  );

endinterface

// File: rtl/sync_fifo_flush.sv
// Power-of-two FIFO with a synchronous flush; extra pointer MSB distinguishes full from empty.
module sync_fifo_flush #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + CW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: owns the PC, pipelines requests to imem and buffers responses for ID.
// Optional FETCH_QUEUE_PERF_EN adds saturating stall/flush performance counters.
module fetch_queue_unit import fetch_pkg::*; #(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                DATA_W   = FETCH_DATA_W,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = FETCH_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  fetch_queue_unit_if.master bus
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  fetch_state_e      state;
  logic [ADDR_W-1:0] fetch_pc, pend_pc;
  logic [CW-1:0]     outstanding, drop_cnt, q_count, pend_count;
  logic [CW:0]       credit_used;
  logic              q_full, q_empty, pend_full, pend_empty;
  logic              grant, rsp_keep, pop;
  entry_t            q_din, q_dout;

  // Every request reserves a queue slot, so responses can never overflow the queue.
  assign credit_used   = {1'b0, q_count} + {1'b0, outstanding};
  assign bus.imem_req  = (state == S_RUN) & ~branch_taken & (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_addr = fetch_pc;
  assign grant         = bus.imem_req & bus.imem_gnt;

  assign rsp_keep      = bus.imem_rvalid & (drop_cnt == '0) & ~branch_taken;
  assign pop           = bus.out_valid & bus.out_ready & ~branch_taken;
  assign q_din         = '{pc: pend_pc, inst: bus.imem_rdata};

  assign bus.out_valid = ~q_empty;
  assign bus.out_pc    = q_dout.pc;
  assign bus.out_inst  = q_dout.inst;

  // Addresses of live requests; stale ones are flushed on redirect and never popped.
  sync_fifo_flush #(.DATA_W(ADDR_W), .DEPTH(DEPTH)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (grant),
    .din   (fetch_pc),
    .pop   (rsp_keep),
    .dout  (pend_pc),
    .count (pend_count),
    .full  (pend_full),
    .empty (pend_empty)
  );

  sync_fifo_flush #(.DATA_W($bits(entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst   (rst),
    .flush (branch_taken),
    .push  (rsp_keep),
    .din   (q_din),
    .pop   (pop),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(grant) - CW'(bus.imem_rvalid);
      if (branch_taken) begin
        state    <= S_REDIRECT;
        fetch_pc <= branch_addr;
        // A response landing in the branch cycle is already discarded, so it is not counted.
        drop_cnt <= outstanding - CW'(bus.imem_rvalid);
      end else begin
        case (state)
          S_BOOT:     state <= S_RUN;
          S_RUN:      state <= S_RUN;
          S_REDIRECT: state <= S_RUN;
          default:    state <= S_BOOT;
        endcase
        if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        if (bus.imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [CW:0] flush_now;
  logic [32:0] flush_sum;

  // Queued entries plus in-flight responses not already doomed by an earlier branch.
  assign flush_now = {1'b0, q_count} + {1'b0, outstanding - drop_cnt};
  assign flush_sum = {1'b0, perf_flush_cnt} + 33'(flush_now);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (branch_taken)
        perf_flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
    end
  end
`endif

  a_outstanding_max: assert property (@(posedge clk) disable iff (!rst)
    outstanding <= CW'(DEPTH));
  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(q_full && rsp_keep && !pop));
  a_pend_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(pend_full && grant && !rsp_keep));
  a_pend_has_entry: assert property (@(posedge clk) disable iff (!rst)
    !(rsp_keep && pend_empty));
  a_pend_le_outstanding: assert property (@(posedge clk) disable iff (!rst)
    pend_count <= outstanding);

endmodule
